// File: rtl/hog_frame_sched_pkg.sv
// Shared state encoding and default geometry for the HOG frame scheduler.
package hog_frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_REQ,
    S_PRESENT,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam int PIX_W_DEF = 8;
  localparam int PIX_N_DEF = 96;
  localparam int MEM_W_DEF = 64;

  localparam int DET_W = PIX_W_DEF * PIX_N_DEF;
  localparam int BEATS = DET_W / MEM_W_DEF;
  localparam bit DET_W_ALIGNED = (DET_W % MEM_W_DEF) == 0;

  function automatic int beats_of(input int det_w, input int mem_w);
    return det_w / mem_w;
  endfunction

endpackage

// File: rtl/hog_chunk_fetch.sv
// Fetches one pixel group as BEATS memory words into a staging register,
// one read outstanding at a time; the address runs on across groups.
module hog_chunk_fetch #(
  parameter int MEM_W = 64,
  parameter int MA_W  = 20,
  parameter int DET_W = 768,
  parameter int BEATS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MA_W-1:0]  base,
  input  logic             go,
  input  logic             take,
  output logic             mem_rd,
  output logic [MA_W-1:0]  mem_addr,
  input  logic             mem_rvalid,
  input  logic [MEM_W-1:0] mem_rdata,
  output logic             stage_full,
  output logic [DET_W-1:0] stage
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic          pending;
  logic [BW-1:0] beat;

  assign mem_rd = go && !stage_full && !pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      beat       <= '0;
      pending    <= 1'b0;
      stage_full <= 1'b0;
      stage      <= '0;
    end else if (load) begin
      mem_addr   <= base;
      beat       <= '0;
      pending    <= 1'b0;
      stage_full <= 1'b0;
    end else begin
      if (take)
        stage_full <= 1'b0;
      if (mem_rd) begin
        pending <= 1'b1;
      end else if (pending && mem_rvalid) begin
        // new word enters at the top so the first beat ends up lowest
        pending  <= 1'b0;
        stage    <= DET_W'({mem_rdata, stage} >> MEM_W);
        mem_addr <= mem_addr + 1'b1;
        if (beat == LAST_BEAT) begin
          beat       <= '0;
          stage_full <= 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hog_frame_sched.sv
// Frame scheduler: feeds pixel groups to the HOG/SVM detector, collects
// per-window results, and reports frame completion or drain timeout.
module hog_frame_sched
  import hog_frame_sched_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int PIX_N   = PIX_N_DEF,
  parameter int MEM_W   = MEM_W_DEF,
  parameter int MA_W    = 20,
  parameter int CHUNK_N = 1200,
  parameter int SW_W    = 11,
  parameter int SW_LAST = 1259,
  parameter int TO_W    = 12,
  parameter int HC_W    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MA_W-1:0]        frame_base,
  output logic                   mem_rd,
  output logic [MA_W-1:0]        mem_addr,
  input  logic                   mem_rvalid,
  input  logic [MEM_W-1:0]       mem_rdata,
  input  logic                   det_request,
  output logic                   det_ready,
  output logic [PIX_W*PIX_N-1:0] det_data,
  input  logic                   det_valid,
  input  logic                   det_is_person,
  input  logic [SW_W-1:0]        det_sw_id,
  output logic                   hit_valid,
  output logic [SW_W-1:0]        hit_sw_id,
  output logic [HC_W-1:0]        hit_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int F_DET_W = PIX_W * PIX_N;
  localparam int F_BEATS = beats_of(F_DET_W, MEM_W);
  localparam int CC_W    = $clog2(CHUNK_N + 1);
  localparam logic [CC_W-1:0] CHUNK_LAST = CC_W'(CHUNK_N - 1);
  localparam logic [SW_W-1:0] SW_END     = SW_W'(SW_LAST);
  localparam logic [TO_W-1:0] TO_LAST    = {TO_W{1'b1}} - 1'b1;

  if (!DET_W_ALIGNED || (F_DET_W % MEM_W) != 0) begin : g_width_check
    $error("pixel group width must be a multiple of the memory width");
  end

  state_t               state;
  logic [CC_W-1:0]      chunk_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic                 last_seen;
  logic                 start_ok;
  logic                 stage_full;
  logic [F_DET_W-1:0]   stage;
  logic                 watching;
  logic                 res_last;

  assign start_ok = (state == S_IDLE) && start;
  assign watching = (state == S_FETCH) || (state == S_WAIT_REQ) ||
                    (state == S_PRESENT) || (state == S_DRAIN);
  assign res_last = det_valid && (det_sw_id == SW_END);

  hog_chunk_fetch #(
    .MEM_W (MEM_W),
    .MA_W  (MA_W),
    .DET_W (F_DET_W),
    .BEATS (F_BEATS)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .load       (start_ok),
    .base       (frame_base),
    .go         (state == S_FETCH),
    .take       (state == S_PRESENT),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stage_full (stage_full),
    .stage      (stage)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      chunk_cnt <= '0;
      to_cnt    <= '0;
      last_seen <= 1'b0;
      det_ready <= 1'b0;
      det_data  <= '0;
      hit_valid <= 1'b0;
      hit_sw_id <= '0;
      hit_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      det_ready <= 1'b0;
      done      <= 1'b0;
      hit_valid <= 1'b0;

      if (watching && det_valid && det_is_person) begin
        hit_valid <= 1'b1;
        hit_sw_id <= det_sw_id;
        if (hit_count != {HC_W{1'b1}})
          hit_count <= hit_count + 1'b1;
      end
      // the final window can report before the last group is handed over
      if (watching && res_last)
        last_seen <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            hit_count <= '0;
            err       <= 1'b0;
            chunk_cnt <= '0;
            to_cnt    <= '0;
            last_seen <= 1'b0;
          end
        end
        S_FETCH: begin
          if (stage_full)
            state <= S_WAIT_REQ;
        end
        S_WAIT_REQ: begin
          if (det_request) begin
            state     <= S_PRESENT;
            det_ready <= 1'b1;
            det_data  <= stage;
          end
        end
        S_PRESENT: begin
          chunk_cnt <= chunk_cnt + 1'b1;
          if (chunk_cnt == CHUNK_LAST) begin
            state  <= S_DRAIN;
            to_cnt <= '0;
          end else begin
            state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (last_seen || res_last) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else if (det_valid) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
            err    <= 1'b1;
            state  <= S_FIN;
            done   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hog_frame_sched.md
Name: hog_frame_sched

Overview:
- Frame-level scheduler in front of the person-detection pipeline (HOG feature extractor + SVM).
- On start, it fetches a frame from word-addressed memory, PIX_N pixels at a time, and serves each group to the detector's request/ready handshake. The next group is prefetched into a staging register while the current one is consumed.
- It collects per-slide-window SVM results, reports positive windows, and signals frame completion or timeout.

Parameters:
- PIX_W, 8, pixel width
- PIX_N, 96, pixels per detector transfer
- MEM_W, 64, memory read-data width; PIX_W*PIX_N must be a multiple of MEM_W (BEATS = PIX_W*PIX_N/MEM_W = 12)
- MA_W, 20, memory word-address width
- CHUNK_N, 1200, PIX_N-pixel groups per frame
- SW_W, 11, slide-window index width
- SW_LAST, 1259, sw_id of the final window of a frame
- TO_W, 12, drain-timeout counter width (timeout = 2^TO_W - 1 cycles)
- HC_W, 11, hit-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle start pulse, sampled only in IDLE
- frame_base  in  MA_W  first word address of the frame, captured on start
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  MA_W  read word address, valid with mem_rd
- mem_rvalid  in  1  read data valid
- mem_rdata  in  MEM_W  read data
- det_request  in  1  detector wants the next pixel group (level)
- det_ready  out  1  one-cycle pulse: det_data is valid
- det_data  out  PIX_W*PIX_N  pixel group, held stable until the next det_ready
- det_valid  in  1  SVM result valid
- det_is_person  in  1  SVM decision
- det_sw_id  in  SW_W  window index of the result
- hit_valid  out  1  one-cycle pulse per positive window
- hit_sw_id  out  SW_W  window index of the hit
- hit_count  out  HC_W  positive windows this frame, saturating
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of frame
- err  out  1  drain timed out; sticky until the next accepted start

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Chunk, beat, address, timeout and hit counters are cleared. Reset asserted mid-frame abandons the frame with no done pulse. A mem_rvalid arriving after reset is ignored.
- States: IDLE, FETCH, WAIT_REQ, PRESENT, DRAIN, FIN.
- IDLE: on start, capture frame_base, clear hit_count, err and counters, then go to FETCH. Start outside IDLE is ignored.
- FETCH: at most one read outstanding.
  - Issue mem_rd with mem_addr = next address; wait for mem_rvalid.
  - Shift mem_rdata into the staging register so the first beat occupies the lowest MEM_W bits, then increment the address.
  - After BEATS beats go to WAIT_REQ.
  - Minimum FETCH time with 1-cycle memory latency is 2*BEATS cycles.
- WAIT_REQ: stay until det_request=1, then go to PRESENT.
- PRESENT: lasts one cycle.
  - det_data <= staging; det_ready=1 for exactly this cycle; increment chunk_cnt.
  - If chunk_cnt reaches CHUNK_N go to DRAIN, else go to FETCH (prefetch the next group).
  - det_request is not sampled again until WAIT_REQ.
- DRAIN: count idle cycles and reset the count on any det_valid.
  - det_valid with det_sw_id == SW_LAST goes to FIN.
  - The counter reaching all-ones sets err and goes to FIN.
- FIN: done=1 for one cycle, then go to IDLE. busy drops in the same cycle that IDLE is entered.
- Results are monitored in FETCH, WAIT_REQ, PRESENT and DRAIN. det_valid && det_is_person gives hit_valid=1 and hit_sw_id=det_sw_id on the next cycle (registered, 1-cycle latency). hit_count increments at the same time and saturates at all-ones.
- The SW_LAST result may arrive before DRAIN. It is latched, and DRAIN then exits to FIN on its first cycle.
- A hit in the same cycle as the SW_LAST result is still reported and counted.
- Address wraps modulo 2^MA_W.
- Total memory reads per frame = CHUNK_N*BEATS; det_ready pulses per frame = CHUNK_N.

Decomposition:
- Shared package holds:
  - state encoding enum;
  - BEATS constant;
  - DET_W = PIX_W*PIX_N;
  - a compile-time check that DET_W % MEM_W == 0.
- One natural sub-module: hog_chunk_fetch, covering the beat counter, address generator and staging shift register. Interface: go, base/next address, mem port, stage_full, staging data.
- The FSM and result tracking stay in the top module.

Test Plan:
- Small config CHUNK_N=3, BEATS=12, 1-cycle memory, det_request held high, SW_LAST result injected after the third det_ready -> 36 mem_rd at consecutive addresses from frame_base; 3 det_ready pulses with data matching memory contents; one done pulse; err=0.
- Memory latency 5 cycles, det_request asserted 40 cycles late each chunk -> det_data stable between pulses; no second mem_rd while one is outstanding.
- Results at sw_id 7 (person), 8 (not person), SW_LAST (person) -> hit_valid pulses carrying sw_id 7 and 1259; hit_count=2; done follows.
- No SW_LAST result after the last chunk -> done and err=1 exactly 4095 cycles after the last det_valid; err clears on the next start.
- rst asserted mid-FETCH with a read outstanding -> outputs 0 and FSM in IDLE; the late mem_rvalid is ignored; a new start fetches from the new frame_base.
- start pulsed while busy -> ignored, and frame_base is not recaptured; HC_W=2 with 5 hits -> hit_count saturates at 3.
